add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: WIDTH, default 32, operand width in bits.
REQ-003 Ports: clk  input  1  single clock, all state on rising edge.
REQ-004 Ports: rst_n  input  1  asynchronous active-low reset.
REQ-005 Ports: req_valid  input  N_REQ  per-requester operation valid.
REQ-006 Ports: req_ready  output  N_REQ  per-requester accept, at most one bit set.
REQ-007 Ports: req_a, req_b  input  N_REQ*WIDTH each  operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Ports: req_cin  input  N_REQ  carry-in for an unchained operation.
REQ-009 Ports: req_chain  input  N_REQ  1 = this word is not the last of a multi-word add; lock the adder and forward the carry.
REQ-010 Ports: rsp_valid  output  1  result held in output register.
REQ-011 Ports: rsp_ready  input  1  downstream accepts the result.
REQ-012 Ports: rsp_sum  output  WIDTH  sum.
REQ-013 Ports: rsp_cout  output  1  carry-out.
REQ-014 Ports: rsp_id  output  clog2(N_REQ)  index of the requester that owns the result.

Function
REQ-015 The block SHALL contain one combinational WIDTH-bit carry-select adder (4-bit groups), shared by all requesters.
REQ-016 Slot free condition: free = !rsp_valid || rsp_ready; no grant when free=0.
REQ-017 Grant SHALL be round-robin: search starts at last_grant+1 mod N_REQ, and the first valid requester wins; last_grant resets to N_REQ-1, so requester 0 has priority first.
REQ-018 req_ready[g] SHALL be 1 only for the granted g when free=1 and req_valid[g]=1; it is combinational from req_valid, lock state and rsp_ready.
REQ-019 Accept occurs when req_valid[g] && req_ready[g].
REQ-020 On accept, rsp_sum/rsp_cout/rsp_id SHALL be loaded from the adder on that edge, and rsp_valid SHALL be set; latency is 1 cycle.
REQ-021 Throughput SHALL be one operation per cycle when rsp_ready=1 (drain and load on the same edge).
REQ-022 With no accept and rsp_ready=1, rsp_valid SHALL clear; under rsp_valid=1 && rsp_ready=0, all rsp_* SHALL hold stable.
REQ-023 Lock FSM states: UNLOCKED and LOCKED(owner, carry_reg).
REQ-024 UNLOCKED -> LOCKED on accept with req_chain[g]=1: owner<=g, carry_reg<=adder cout.
REQ-025 LOCKED -> LOCKED on an owner accept with chain=1; carry_reg is updated.
REQ-026 LOCKED -> UNLOCKED on an owner accept with chain=0.
REQ-027 Adder carry-in SHALL be carry_reg in LOCKED, else req_cin[g]; req_cin is ignored while LOCKED.
REQ-028 In LOCKED, only the owner SHALL be grantable; others stall even if the owner's req_valid=0 (no timeout); last_grant is not advanced by owner grants.
REQ-029 Sum width: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(WIDTH+1); no saturation.

Reset
REQ-030 While rst_n=0: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, req_ready=0, lock=UNLOCKED, carry_reg=0, last_grant=N_REQ-1.
REQ-031 Reset asserted mid-chain SHALL abandon the chain; the first post-reset op uses req_cin.
REQ-032 First accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Req0 a=0xFFFFFFFF b=0x00000001 cin=0 chain=0, rsp_ready=1 -> next cycle rsp_sum=0x00000000, rsp_cout=1, rsp_id=0.
REQ-034 All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one result per cycle, rsp_id matches.
REQ-035 Req2 64-bit add 0x00000001_FFFFFFFF + 0x00000000_00000001: word0 chain=1, word1 chain=0, while req1 also valid -> rsp_id 2,2 back-to-back with sums 0x00000000 (cout 1) then 0x00000002 (cout 0), and req1 granted only after the unlock.
REQ-036 rsp_ready=0 for 3 cycles with result 0x12345678 pending -> rsp_* stable, all req_ready=0; rsp_ready=1 -> a new accept on the same edge.
REQ-037 Lock owner 1 drops req_valid for 2 cycles mid-chain -> req_ready stays 0 for others, and carry_reg is retained and used on the resumed word.
REQ-038 rst_n pulsed low while LOCKED -> all outputs 0, and the next req3 op with cin=1, a=b=0 -> rsp_sum=0x00000001.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding one shared carry-select adder with a registered result slot.
// A requester can lock the adder across words of a multi-word add; its carry is forwarded.
module add_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ-1:0]           req_cin,
  input  logic [N_REQ-1:0]           req_chain,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned NG  = (WIDTH + 3) / 4;
  localparam int unsigned PW  = NG * 4;

  typedef enum logic [0:0] {StUnlocked, StLocked} lock_e;

  lock_e              state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               carry_q, carry_d;
  logic [IDW-1:0]     last_q, last_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  logic               free, found, gnt_vld, accept;
  logic [IDW-1:0]     rr_idx, gnt_idx;
  int unsigned        cand;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_cin;

  logic [PW-1:0]      a_pad, b_pad, sum_pad;
  logic [NG:0]        gc;
  logic [4:0]         s0, s1, ssel;
  logic [PW:0]        full;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  // Grant selection: owner only while locked, otherwise round-robin after last_q.
  always_comb begin
    free   = !rsp_valid_q || rsp_ready;
    found  = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_q) + k) % N_REQ;
      if (!found && req_valid[IDW'(cand)]) begin
        found  = 1'b1;
        rr_idx = IDW'(cand);
      end
    end
    if (state_q == StLocked) begin
      gnt_idx = owner_q;
      gnt_vld = req_valid[owner_q];
    end else begin
      gnt_idx = rr_idx;
      gnt_vld = found;
    end
    accept = free && gnt_vld;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = rst_n && accept && (gnt_idx == IDW'(i));
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_a = req_a[i*WIDTH +: WIDTH];
        op_b = req_b[i*WIDTH +: WIDTH];
      end
    end
    op_cin = (state_q == StLocked) ? carry_q : req_cin[gnt_idx];
  end

  // Carry-select adder: each 4-bit group precomputes both carry-in cases.
  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[WIDTH-1:0] = op_a;
    b_pad[WIDTH-1:0] = op_b;
    sum_pad = '0;
    s0      = '0;
    s1      = '0;
    ssel    = '0;
    gc      = '0;
    gc[0]   = op_cin;
    for (int unsigned g = 0; g < NG; g++) begin
      s0   = {1'b0, a_pad[g*4 +: 4]} + {1'b0, b_pad[g*4 +: 4]};
      s1   = s0 + 5'd1;
      ssel = gc[g] ? s1 : s0;
      sum_pad[g*4 +: 4] = ssel[3:0];
      gc[g+1] = ssel[4];
    end
    full     = {gc[NG], sum_pad};
    add_sum  = full[WIDTH-1:0];
    add_cout = full[WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    carry_d     = carry_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_id_d    = gnt_idx;
      unique case (state_q)
        StUnlocked: begin
          last_d = gnt_idx;
          if (req_chain[gnt_idx]) begin
            state_d = StLocked;
            owner_d = gnt_idx;
            carry_d = add_cout;
          end
        end
        StLocked: begin
          if (req_chain[gnt_idx]) begin
            carry_d = add_cout;
          end else begin
            state_d = StUnlocked;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUnlocked;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      last_q      <= IDW'(N_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      carry_q     <= carry_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: arbitration order, chaining, back-pressure and reset.
module tb_add_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_chain;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_chain (req_chain),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic chain);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_chain[i]    = chain;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] sum, input logic cout,
                           input logic [1:0] id);
    check_eq({tag, ".valid"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, ".sum"}, 64'(rsp_sum), 64'(sum));
    check_eq({tag, ".cout"}, 64'(rsp_cout), 64'(cout));
    check_eq({tag, ".id"}, 64'(rsp_id), 64'(id));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_chain = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // Reset values are forced even with requests pending.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_eq("rst.ready", 64'(req_ready), 64'd0);
    check_eq("rst.valid", 64'(rsp_valid), 64'd0);
    check_eq("rst.sum", 64'(rsp_sum), 64'd0);
    check_eq("rst.cout", 64'(rsp_cout), 64'd0);
    check_eq("rst.id", 64'(rsp_id), 64'd0);

    // Wrap-around add from requester 0 right after reset release.
    do_reset();
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    req_valid = 4'b0001;
    #1;
    check_eq("wrap.ready", 64'(req_ready), 64'b0001);
    tick();
    check_rsp("wrap", 32'h0, 1'b1, 2'd0);
    req_valid = '0;
    tick();
    check_eq("drain.valid", 64'(rsp_valid), 64'd0);

    // All requesters valid: round-robin 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'h10, 1'b0, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check_rsp($sformatf("rr%0d", k), 32'((k % 4) + 1 + 16), 1'b0, 2'(k % 4));
    end

    // Chained 64-bit add by requester 2 while requester 1 waits.
    do_reset();
    set_op(1, 32'h0, 32'h0, 1'b0, 1'b0);
    req_valid = 4'b0010;
    tick();
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    set_op(1, 32'h5, 32'h5, 1'b0, 1'b0);
    req_valid = 4'b0110;
    #1;
    check_eq("ch0.ready", 64'(req_ready), 64'b0100);
    tick();
    check_rsp("ch0", 32'h0, 1'b1, 2'd2);
    set_op(2, 32'h0000_0001, 32'h0, 1'b1, 1'b0);  // cin must be ignored while locked
    #1;
    check_eq("ch1.ready", 64'(req_ready), 64'b0100);
    tick();
    check_rsp("ch1", 32'h2, 1'b0, 2'd2);
    req_valid = 4'b0010;
    #1;
    check_eq("ch2.ready", 64'(req_ready), 64'b0010);
    tick();
    check_rsp("ch2", 32'hA, 1'b0, 2'd1);

    // Back-pressure: pending result holds, then drain and load on one edge.
    do_reset();
    rsp_ready = 1'b0;
    set_op(0, 32'h1234_5670, 32'h8, 1'b0, 1'b0);
    req_valid = 4'b0001;
    tick();
    set_op(0, 32'h1, 32'h1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("bp%0d.ready", k), 64'(req_ready), 64'd0);
      tick();
      check_rsp($sformatf("bp%0d", k), 32'h1234_5678, 1'b0, 2'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp.release.ready", 64'(req_ready), 64'b0001);
    tick();
    check_rsp("bp.new", 32'h2, 1'b0, 2'd0);

    // Owner 1 pauses mid-chain; requester 3 must stall and carry must survive.
    do_reset();
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    set_op(3, 32'h7, 32'h7, 1'b0, 1'b0);
    req_valid = 4'b1010;
    tick();
    check_rsp("gap0", 32'hFFFF_FFFE, 1'b1, 2'd1);
    req_valid = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq($sformatf("gap%0d.ready", k + 1), 64'(req_ready), 64'd0);
      tick();
    end
    check_eq("gap.drained", 64'(rsp_valid), 64'd0);
    set_op(1, 32'h0, 32'h0, 1'b0, 1'b0);
    req_valid = 4'b1010;
    #1;
    check_eq("gap.resume.ready", 64'(req_ready), 64'b0010);
    tick();
    check_rsp("gap.resume", 32'h1, 1'b0, 2'd1);
    #1;
    check_eq("gap.unlock.ready", 64'(req_ready), 64'b1000);
    tick();
    check_rsp("gap.r3", 32'hE, 1'b0, 2'd3);

    // Reset while locked abandons the chain.
    do_reset();
    set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    req_valid = 4'b0010;
    tick();
    check_rsp("lrst.lock", 32'h0, 1'b1, 2'd1);
    rst_n = 1'b0;
    #1;
    check_eq("lrst.ready", 64'(req_ready), 64'd0);
    check_eq("lrst.valid", 64'(rsp_valid), 64'd0);
    check_eq("lrst.sum", 64'(rsp_sum), 64'd0);
    check_eq("lrst.cout", 64'(rsp_cout), 64'd0);
    check_eq("lrst.id", 64'(rsp_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1000;
    set_op(3, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check_eq("lrst.r3.ready", 64'(req_ready), 64'b1000);
    tick();
    check_rsp("lrst.r3", 32'h1, 1'b0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
